mainm_cache: RTL and testbench
==============================

# mainm_cache

Direct-mapped, write-through read cache between the memory mapper's main-memory port and the serial-boot/PSRAM path (the `mainm_*_c` side of `serialboot`). It serves CPU word reads from on-chip storage and refills 4-word lines from the slow PSRAM controller on a miss. Writes always go to memory and update the cache only on a hit. A `flush` input invalidates every line so software can stay coherent after serial-boot loads.

## Interface
- `INDEX_BITS`, default 6: number of lines is 2^INDEX_BITS; line = 4 words = 16 bytes.
- `clk` in 1: main clock (`clk_main` domain).
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: one-cycle pulse; invalidate all lines.
- `a` in 32: CPU-side byte address; a[1:0] ignored.
- `d` in 32: CPU-side write data.
- `we` in 1: write request; level, held until `ready`.
- `rd` in 1: read request; level, held until `ready`.
- `spo` out 32: read data, valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `a_mem` out 32: memory-side address, word-aligned.
- `d_mem` out 32: memory-side write data.
- `we_mem` out 1: memory write request; level until `ready_mem`.
- `rd_mem` out 1: memory read request; level until `ready_mem`.
- `spo_mem` in 32: memory read data, valid with `ready_mem`.
- `ready_mem` in 1: memory completion pulse.

## Operation
- Address split: offset = a[3:2], index = a[INDEX_BITS+3:4], tag = a[31:INDEX_BITS+4].
- Storage: data RAM 2^INDEX_BITS×4×32 with synchronous read; tag RAM; valid bits in flops so they can be cleared in one cycle.
- States: IDLE, COMPARE, REFILL, WRITE, RESP.
- IDLE: on `we`|`rd`, latch a/d/op and start the tag/data read, then go to COMPARE. If `we` and `rd` are both high, the request is a write.
- COMPARE: hit = valid[index] && tag match.
  - read hit: `spo` ← word[offset] → RESP.
  - read miss: k ← 0 → REFILL.
  - write (hit or miss): → WRITE.
- REFILL: `rd_mem`=1 with `a_mem` = {tag, index, k, 2'b00}. On `ready_mem`, store `spo_mem` into word k and capture it for `spo` if k == offset.
  - k=3 with `ready_mem`: write tag, set valid → RESP.
  - otherwise k++ and drop `rd_mem` for one cycle before the next word.
  - Words are fetched 0..3 in order.
- WRITE: `we_mem`=1, `a_mem` = {a[31:2],2'b00}, `d_mem` = d. On `ready_mem`, if COMPARE reported a hit, write d into word[offset]; the line is not allocated on a miss → RESP.
- RESP: `ready`=1 for exactly one cycle → IDLE.
- Flush:
  - In IDLE with no request that cycle: clear all valid bits.
  - Otherwise set `flush_pend`; clear valid bits and `flush_pend` on entry to IDLE, before the next lookup.
  - A refill completing in the same cycle as the deferred clear ends invalid.
- Reset:
  - Valid bits all 0; state IDLE; k=0; `flush_pend`=0.
  - `ready`, `spo`, `a_mem`, `d_mem`, `we_mem`, `rd_mem` all 0.
  - Reset mid-refill or mid-write abandons the access immediately; memory-side requests drop the next cycle.

## Timing
- Request sampled at edge E0 (in IDLE). COMPARE runs in cycle E0–E1.
- Read hit: `ready`/`spo` registered high in cycle E1–E2 (2-cycle latency).
- Read miss: `ready` is high one cycle after the 4th `ready_mem`. Each memory word costs memory latency + 1 idle cycle.
- Write: `ready` is high one cycle after the `ready_mem` for the write.
- The requester must drop `rd`/`we` at the edge ending the `ready` cycle. IDLE may accept a new request in the very next cycle.
- Memory-side `a_mem`/`d_mem` are stable while `rd_mem`/`we_mem` is high. At most one memory request is outstanding.
- `ready_mem` outside REFILL/WRITE is ignored.

## Test plan
- Cold read: flush, read 0x2000_0104 with memory returning 0x1111_0000+k for word k → 4 `rd_mem` at 0x2000_0100/104/108/10C; `spo`=0x1111_0001.
- Read hit: immediately read 0x2000_0108 → `ready` 2 cycles after `rd`, `spo`=0x1111_0002, no `rd_mem`.
- Conflict miss (INDEX_BITS=6): read 0x2000_0504 (same index, different tag) → refill from 0x2000_0500; a following read of 0x2000_0104 refills again.
- Write hit then read: write 0xDEAD_BEEF to 0x2000_050C → `we_mem` with `a_mem`=0x2000_050C, `d_mem`=0xDEAD_BEEF; the next read returns 0xDEAD_BEEF with no `rd_mem`. A write miss to 0x2000_0900 must not allocate (the next read refills).
- Flush while busy: assert `flush` during REFILL word 1 → the refill completes and `ready` pulses. A re-read of the same address misses and refills.
- Reset mid-refill: assert `rst` after word 2 → all outputs 0 next cycle. A re-read after reset performs a full 4-word refill.

Source files
------------

// File: rtl/mainm_cache.sv
// Direct-mapped, write-through read cache in front of the PSRAM path.
// 4-word lines are refilled in order on a read miss; writes go straight to memory.
module mainm_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    output logic [31:0] a_mem,
    output logic [31:0] d_mem,
    output logic        we_mem,
    output logic        rd_mem,
    input  logic [31:0] spo_mem,
    input  logic        ready_mem,
    output logic [2:0]  state_dbg
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_REFILL, S_WRITE, S_RESP} state_t;

    // Handshake: rd/we are levels held until the one-cycle ready pulse;
    // rd_mem/we_mem are levels held (with stable a_mem/d_mem) until ready_mem.
    state_t                 state_q, state_d;
    logic [31:2]            a_q, a_d;
    logic [31:0]            d_q, d_d;
    logic                   wr_op_q, wr_op_d;
    logic                   hit_q, hit_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [1:0]             k_q, k_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic [31:0]            spo_q, spo_d;
    logic [31:0]            a_mem_q, a_mem_d;
    logic [31:0]            d_mem_q, d_mem_d;
    logic                   we_mem_q, we_mem_d;
    logic                   rd_mem_q, rd_mem_d;

    logic [31:0]            data_ram [LINES*4];
    logic [TAG_BITS-1:0]    tag_ram [LINES];
    logic [31:0]            rd_data_q;
    logic [TAG_BITS-1:0]    rd_tag_q;

    logic                   req, rd_en, hit, ram_we, tag_we;
    logic [INDEX_BITS+1:0]  ram_waddr;
    logic [31:0]            ram_wdata;
    logic [INDEX_BITS-1:0]  idx_in, idx_q;
    logic [1:0]             off_in, off_q;
    logic [TAG_BITS-1:0]    tag_q;
    logic                   unused_addr_bits;

    assign req              = we | rd;
    assign rd_en            = (state_q == S_IDLE) && req;
    assign idx_in           = a[INDEX_BITS+3:4];
    assign off_in           = a[3:2];
    assign idx_q            = a_q[INDEX_BITS+3:4];
    assign off_q            = a_q[3:2];
    assign tag_q            = a_q[31:INDEX_BITS+4];
    assign hit              = valid_q[idx_q] && (rd_tag_q == tag_q);
    assign unused_addr_bits = ^a[1:0];

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        d_d          = d_q;
        wr_op_d      = wr_op_q;
        hit_d        = hit_q;
        flush_pend_d = flush_pend_q;
        k_d          = k_q;
        valid_d      = valid_q;
        ready_d      = 1'b0;
        spo_d        = spo_q;
        a_mem_d      = a_mem_q;
        d_mem_d      = d_mem_q;
        we_mem_d     = we_mem_q;
        rd_mem_d     = rd_mem_q;
        ram_we       = 1'b0;
        ram_waddr    = {idx_q, off_q};
        ram_wdata    = d_q;
        tag_we       = 1'b0;

        // A flush that cannot act immediately is remembered until the return to IDLE.
        if (flush && !(state_q == S_IDLE && !req)) flush_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d     = a[31:2];
                    d_d     = d;
                    wr_op_d = we;
                    state_d = S_COMPARE;
                end else if (flush) begin
                    valid_d = '0;
                end
            end
            S_COMPARE: begin
                hit_d = hit;
                if (wr_op_q) begin
                    we_mem_d = 1'b1;
                    a_mem_d  = {a_q, 2'b00};
                    d_mem_d  = d_q;
                    state_d  = S_WRITE;
                end else if (hit) begin
                    spo_d   = rd_data_q;
                    ready_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    k_d      = 2'd0;
                    rd_mem_d = 1'b1;
                    a_mem_d  = {a_q[31:4], 2'b00, 2'b00};
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                if (rd_mem_q) begin
                    if (ready_mem) begin
                        ram_we    = 1'b1;
                        ram_waddr = {idx_q, k_q};
                        ram_wdata = spo_mem;
                        rd_mem_d  = 1'b0;
                        if (k_q == off_q) spo_d = spo_mem;
                        if (k_q == 2'd3) begin
                            tag_we         = 1'b1;
                            valid_d[idx_q] = 1'b1;
                            ready_d        = 1'b1;
                            k_d            = 2'd0;
                            state_d        = S_RESP;
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end
                end else begin
                    // One idle cycle between words, then request the next one.
                    rd_mem_d = 1'b1;
                    a_mem_d  = {a_q[31:4], k_q, 2'b00};
                end
            end
            S_WRITE: begin
                if (ready_mem) begin
                    we_mem_d = 1'b0;
                    ram_we   = hit_q;
                    ready_d  = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (flush_pend_q || flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            d_q          <= '0;
            wr_op_q      <= 1'b0;
            hit_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            k_q          <= 2'd0;
            valid_q      <= '0;
            ready_q      <= 1'b0;
            spo_q        <= '0;
            a_mem_q      <= '0;
            d_mem_q      <= '0;
            we_mem_q     <= 1'b0;
            rd_mem_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            d_q          <= d_d;
            wr_op_q      <= wr_op_d;
            hit_q        <= hit_d;
            flush_pend_q <= flush_pend_d;
            k_q          <= k_d;
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            spo_q        <= spo_d;
            a_mem_q      <= a_mem_d;
            d_mem_q      <= d_mem_d;
            we_mem_q     <= we_mem_d;
            rd_mem_q     <= rd_mem_d;
        end
    end

    // Storage arrays carry no reset; validity lives entirely in valid_q.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= data_ram[{idx_in, off_in}];
            rd_tag_q  <= tag_ram[idx_in];
        end
        if (ram_we && !rst) data_ram[ram_waddr] <= ram_wdata;
        if (tag_we && !rst) tag_ram[idx_q] <= tag_q;
    end

    assign spo       = spo_q;
    assign ready     = ready_q;
    assign a_mem     = a_mem_q;
    assign d_mem     = d_mem_q;
    assign we_mem    = we_mem_q;
    assign rd_mem    = rd_mem_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_mainm_cache.sv
// Bench for mainm_cache: PSRAM responder with random latency, and a set/line-level
// cache model whose data always equals the modelled memory (write-through).
module tb_mainm_cache;
    logic        clk = 1'b0;
    logic        rst, flush, we, rd;
    logic [31:0] a, d;
    logic [31:0] spo, a_mem, d_mem;
    logic        ready, we_mem, rd_mem;
    logic [31:0] spo_mem   = '0;
    logic        ready_mem = 1'b0;
    logic [2:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    mainm_cache #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .a(a), .d(d), .we(we), .rd(rd),
        .spo(spo), .ready(ready), .a_mem(a_mem), .d_mem(d_mem), .we_mem(we_mem),
        .rd_mem(rd_mem), .spo_mem(spo_mem), .ready_mem(ready_mem), .state_dbg(state_dbg)
    );

    // Clock/reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment and the model's view of memory
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_a_log[$];
    logic [31:0] wr_d_log[$];
    int          last_rm_cyc = 0;
    int          lat = 0;

    bit          mdl_valid [64];
    logic [27:0] mdl_line  [64];

    function automatic logic [31:0] mem_init(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : mem_init(addr);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        return mdl_mem.exists(addr) ? mdl_mem[addr] : mem_init(addr);
    endfunction

    // PSRAM responder: 0..3 cycles of latency while a request is held
    always begin
        @(posedge clk);
        #1;
        ready_mem = 1'b0;
        if (!rst && (rd_mem || we_mem)) begin
            if (lat == 0) begin
                ready_mem = 1'b1;
                if (we_mem) begin
                    mem[a_mem] = d_mem;
                    wr_a_log.push_back(a_mem);
                    wr_d_log.push_back(d_mem);
                end else begin
                    spo_mem = env_read(a_mem);
                    rd_log.push_back(a_mem);
                end
                last_rm_cyc = cyc;
                lat = $urandom_range(0, 3);
            end else begin
                lat = lat - 1;
            end
        end else begin
            lat = $urandom_range(0, 3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_flush();
        for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk); #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        mdl_flush();
    endtask

    // Driver + scoreboard for one CPU access
    task automatic do_op(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] data, input string tag);
        logic [31:0] wa, got;
        logic [31:0] exp_q[$];
        int          set_i, start, rcyc;
        bit          hit, seen;
        wa    = {addr[31:2], 2'b00};
        set_i = int'(wa[9:4]);
        hit   = mdl_valid[set_i] && (mdl_line[set_i] == wa[31:4]);
        rd_log.delete();
        wr_a_log.delete();
        wr_d_log.delete();
        @(posedge clk); #2;
        a = addr; d = data; we = is_wr; rd = !is_wr || both;
        start = cyc; seen = 1'b0; rcyc = 0; got = '0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                rcyc = cyc;
                got  = spo;
            end
        end
        chk({tag, " ready_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #2;
        we = 1'b0; rd = 1'b0; a = $urandom; d = $urandom;
        @(negedge clk);
        chk({tag, " ready_one_cycle"}, 32'(ready), 32'd0);
        if (is_wr) begin
            chk({tag, " wr_count"}, 32'(wr_a_log.size()), 32'd1);
            if (wr_a_log.size() > 0) begin
                chk({tag, " wr_addr"}, wr_a_log[0], wa);
                chk({tag, " wr_data"}, wr_d_log[0], data);
            end
            chk({tag, " rd_count"}, 32'(rd_log.size()), 32'd0);
            chk({tag, " wr_latency"}, 32'(rcyc), 32'(last_rm_cyc + 1));
            mdl_mem[wa] = data;
        end else begin
            if (!hit) for (int k = 0; k < 4; k++) exp_q.push_back({wa[31:4], 4'b0000} + 32'(k * 4));
            chk({tag, " rd_count"}, 32'(rd_log.size()), 32'(exp_q.size()));
            for (int i = 0; i < rd_log.size() && i < exp_q.size(); i++)
                chk({tag, " refill_addr"}, rd_log[i], exp_q[i]);
            chk({tag, " spo"}, got, mdl_read(wa));
            if (hit) chk({tag, " hit_latency"}, 32'(rcyc - start), 32'd2);
            else     chk({tag, " miss_latency"}, 32'(rcyc), 32'(last_rm_cyc + 1));
            chk({tag, " wr_count"}, 32'(wr_a_log.size()), 32'd0);
            mdl_valid[set_i] = 1'b1;
            mdl_line[set_i]  = wa[31:4];
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " ready"},  32'(ready),  32'd0);
        chk({tag, " spo"},    spo,         32'd0);
        chk({tag, " a_mem"},  a_mem,       32'd0);
        chk({tag, " d_mem"},  d_mem,       32'd0);
        chk({tag, " we_mem"}, 32'(we_mem), 32'd0);
        chk({tag, " rd_mem"}, 32'(rd_mem), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        int          sel;
        rst = 1'b1; flush = 1'b0; we = 1'b0; rd = 1'b0; a = '0; d = '0;
        mdl_flush();
        for (int k = 0; k < 4; k++) begin
            mem[32'h2000_0100 + 32'(k * 4)]     = 32'h1111_0000 + 32'(k);
            mdl_mem[32'h2000_0100 + 32'(k * 4)] = 32'h1111_0000 + 32'(k);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        do_flush();
        do_op(1'b0, 1'b0, 32'h2000_0104, '0, "cold_read");
        do_op(1'b0, 1'b0, 32'h2000_0108, '0, "read_hit");
        do_op(1'b0, 1'b0, 32'h2000_0504, '0, "conflict_a");
        do_op(1'b0, 1'b0, 32'h2000_0104, '0, "conflict_b");
        do_op(1'b0, 1'b0, 32'h2000_0500, '0, "conflict_c");
        do_op(1'b1, 1'b0, 32'h2000_050C, 32'hDEAD_BEEF, "write_hit");
        do_op(1'b0, 1'b0, 32'h2000_050C, '0, "read_after_write");
        do_op(1'b1, 1'b0, 32'h2000_0900, 32'h0BAD_F00D, "write_miss");
        do_op(1'b0, 1'b0, 32'h2000_0900, '0, "read_after_wmiss");
        do_op(1'b1, 1'b1, 32'h2000_0904, 32'h1234_5678, "we_and_rd");
        do_op(1'b0, 1'b0, 32'h2000_0904, '0, "read_after_both");

        fork
            do_op(1'b0, 1'b0, 32'h2000_0A04, '0, "flush_busy");
            begin
                #1;
                for (int i = 0; i < 400 && rd_log.size() < 1; i++) @(negedge clk);
                @(posedge clk); #2;
                flush = 1'b1;
                @(posedge clk); #2;
                flush = 1'b0;
            end
        join
        mdl_flush();
        do_op(1'b0, 1'b0, 32'h2000_0A04, '0, "reread_after_flush");

        for (int n = 0; n < 40; n++) begin
            ra  = 32'h2000_0000 + 32'($urandom_range(0, 1) << 10)
                + 32'($urandom_range(0, 3) << 4) + 32'($urandom_range(0, 3) << 2);
            sel = $urandom_range(0, 9);
            if (sel < 6)       do_op(1'b0, 1'b0, ra, '0, "rand_read");
            else if (sel < 8)  do_op(1'b1, 1'b0, ra, $urandom, "rand_write");
            else if (sel == 8) do_op(1'b1, 1'b1, ra, $urandom, "rand_both");
            else               do_flush();
        end

        // Reset in the middle of a refill, after the second word
        rd_log.delete();
        @(posedge clk); #2;
        a = 32'h2000_0104; rd = 1'b1;
        for (int i = 0; i < 400 && rd_log.size() < 2; i++) @(negedge clk);
        chk("rst_mid words_before", 32'(rd_log.size()), 32'd2);
        @(posedge clk); #2;
        rst = 1'b1; rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("rst_mid");
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rst_mid no_extra_reads", 32'(rd_log.size()), 32'd2);
        mdl_flush();
        do_op(1'b0, 1'b0, 32'h2000_0104, '0, "read_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
